// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the RAM port arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Widest requester vector the pick helper handles, and the pointer width that covers it.
  localparam int RR_MAX = 16;
  localparam int PTR_W  = 4;
  localparam int SUM_W  = PTR_W + 1;

  // One-hot round-robin pick over the low n bits of valid, searching upward from ptr.
  // Rotates the request vector so ptr lands at bit 0, takes the lowest set bit, then
  // maps that position back to the original requester index.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                input logic [PTR_W-1:0]  ptr,
                                                input int                n);
    logic [RR_MAX-1:0] rot;
    logic [RR_MAX-1:0] res;
    logic [SUM_W-1:0]  sum;
    logic [PTR_W-1:0]  idx;
    logic              found;
    rot   = '0;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (i < n) begin
        sum = {1'b0, PTR_W'(i)} + {1'b0, ptr};
        if (sum >= SUM_W'(n)) sum = sum - SUM_W'(n);
        idx    = sum[PTR_W-1:0];
        rot[i] = valid[idx];
      end
    end
    for (int i = 0; i < RR_MAX; i++) begin
      if ((i < n) && !found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, PTR_W'(i)} + {1'b0, ptr};
        if (sum >= SUM_W'(n)) sum = sum - SUM_W'(n);
        idx      = sum[PTR_W-1:0];
        res[idx] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index, search from ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; grant depends only on valid and ptr.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);

  logic [RR_MAX-1:0] valid_wide;
  logic [RR_MAX-1:0] grant_wide;

  // Widen the request vector, pick, and fold the wide one-hot back to N bits
  // (the pick never sets bits at or above N, so the fold is exact).
  always_comb begin
    valid_wide        = '0;
    valid_wide[N-1:0] = valid;
    grant_wide        = rr_pick(valid_wide, PTR_W'(ptr), N);
    grant             = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < RR_MAX; k++) begin
        if ((k % N) == i) grant[i] = grant[i] | grant_wide[k];
      end
    end
  end

  // Encode the one-hot grant into a requester index.
  always_comb begin
    grant_id = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_id = IW'(i);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ clients, with bounded lock for RMW.
// Latency: grant same cycle; response strobe and read data one cycle after the grant.
// Backpressure: req_ready is a one-hot grant; unselected or lock-excluded requesters wait.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int LOCK_MAX   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  arb_state_e            state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         owner;
  logic [CW-1:0]         lock_cnt;
  logic                  rsp_pend;
  logic [IW-1:0]         rsp_id;
  logic [DATA_WIDTH-1:0] rsp_hold;

  logic [NUM_REQ-1:0]    rr_grant;
  logic [IW-1:0]         rr_id;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         gnt_id;
  logic                  gnt_any;
  logic                  lock_more;
  mem_cmd_t              cmd;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .valid    (req_valid),
    .ptr      (ptr),
    .grant    (rr_grant),
    .grant_id (rr_id)
  );

  // Select the grant: round-robin in ARB, owner-only in LOCKED, nothing while in reset.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    if (rst_n) begin
      if (state == ARB) begin
        grant  = rr_grant;
        gnt_id = rr_id;
      end else if (req_valid[owner]) begin
        grant[owner] = 1'b1;
        gnt_id       = owner;
      end
    end
  end

  assign gnt_any = |grant;

  // Mux the granted requester's command onto the RAM port; all-zero when idle.
  always_comb begin
    cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        cmd.we    = req_we[i];
        cmd.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        cmd.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready = grant;
  assign mem_en    = gnt_any;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  // Owner keeps the port only while it still asks and has not used up its lock budget.
  assign lock_more = req_valid[owner] & req_lock[owner] & (lock_cnt < CW'(LOCK_MAX));

  // Arbitration FSM: pointer advance, lock entry, and lock release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      ptr      <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (gnt_any) begin
            ptr <= next_ptr(gnt_id);
            if (req_lock[gnt_id]) begin
              state    <= LOCKED;
              owner    <= gnt_id;
              lock_cnt <= CW'(1);
            end
          end
        end
        LOCKED: begin
          if (lock_more) begin
            lock_cnt <= lock_cnt + 1'b1;
          end else begin
            // Final locked access (or owner gave up): fairness resumes after the owner.
            state    <= ARB;
            ptr      <= next_ptr(owner);
            lock_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Response pipe: remember who was granted so the RAM's next-cycle data is routed to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend <= 1'b0;
      rsp_id   <= '0;
      rsp_hold <= '0;
    end else begin
      rsp_pend <= gnt_any;
      if (gnt_any) rsp_id <= gnt_id;
      if (rsp_pend) rsp_hold <= mem_rdata;
    end
  end

  // Live RAM data during a strobe, last delivered word otherwise.
  assign rsp_rdata = rsp_pend ? mem_rdata : rsp_hold;

  // Decode the registered id into the one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = rsp_pend && (rsp_id == IW'(i));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with an attached read-first RAM and a queue-free reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int LM = 4;
  localparam int DW = 32;
  localparam int AW = 13;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_lock, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;

  logic [AW-1:0]   v_addr  [N];
  logic [DW-1:0]   v_wdata [N];

  logic [DW-1:0]   ram     [0:8191];
  logic [DW-1:0]   ref_mem [0:8191];
  logic            ram_load;
  logic [DW-1:0]   seed;

  int checks;
  int errors;

  // Reference model state (plain integers, spec-level rules)
  int              m_ptr, m_owner, m_cnt, m_pid;
  bit              m_locked, m_pend;
  logic [DW-1:0]   m_pdata, m_last;

  int              obs_g;
  logic [N-1:0]    obs_rsp_vld;
  logic [DW-1:0]   obs_rsp;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = v_addr[i];
      req_wdata[i*DW +: DW] = v_wdata[i];
    end
  end

  mem_port_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] seed_word(input logic [AW-1:0] a);
    return ({19'd0, a} * 32'h9E3779B1) ^ seed;
  endfunction

  // Single-port read-first RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 8192; i++) ram[i] <= seed_word(AW'(i));
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_pid = 0;
    m_locked = 0; m_pend = 0; m_pdata = '0; m_last = '0;
  endtask

  // Expected winner this cycle, or -1
  function automatic int exp_grant();
    int g;
    g = -1;
    if (!m_locked) begin
      for (int j = 0; j < N; j++) begin
        if (g < 0 && req_valid[(m_ptr + j) % N]) g = (m_ptr + j) % N;
      end
    end else if (req_valid[m_owner]) begin
      g = m_owner;
    end
    return g;
  endfunction

  // One clock: check comb outputs against the model, clock, then advance the model
  task automatic tick(input string tag);
    int           g;
    logic [N-1:0] eg;
    #1;
    g  = exp_grant();
    eg = (g >= 0) ? N'(1 << g) : '0;
    obs_g = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) obs_g = i;
    obs_rsp_vld = rsp_valid;
    obs_rsp     = rsp_rdata;
    chk({tag, " ready"},     64'(req_ready), 64'(eg));
    chk({tag, " mem_en"},    64'(mem_en),    64'(g >= 0));
    chk({tag, " mem_we"},    64'(mem_we),    (g >= 0) ? 64'(req_we[g]) : 64'd0);
    chk({tag, " mem_addr"},  64'(mem_addr),  (g >= 0) ? 64'(v_addr[g]) : 64'd0);
    chk({tag, " mem_wdata"}, 64'(mem_wdata), (g >= 0) ? 64'(v_wdata[g]) : 64'd0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), m_pend ? 64'(1 << m_pid) : 64'd0);
    chk({tag, " rsp_rdata"}, 64'(rsp_rdata), m_pend ? 64'(m_pdata) : 64'(m_last));
    @(posedge clk);
    if (m_pend) m_last = m_pdata;
    m_pend = (g >= 0);
    if (g >= 0) begin
      m_pid   = g;
      m_pdata = ref_mem[v_addr[g]];
      if (req_we[g]) ref_mem[v_addr[g]] = v_wdata[g];
    end
    if (!m_locked) begin
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (req_lock[g]) begin m_locked = 1; m_owner = g; m_cnt = 1; end
      end
    end else if (req_valid[m_owner] && req_lock[m_owner] && m_cnt < LM) begin
      m_cnt++;
    end else begin
      m_locked = 0;
      m_ptr    = (m_owner + 1) % N;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] old5;
    checks = 0; errors = 0;
    seed = $urandom;
    ram_load = 1'b1;
    rst_n = 1'b0;
    req_valid = '1; req_lock = '0; req_we = '0;
    for (int i = 0; i < N; i++) begin v_addr[i] = '0; v_wdata[i] = '0; end
    for (int i = 0; i < 8192; i++) ref_mem[i] = seed_word(AW'(i));
    m_reset();

    // Reset state: no grant even with every requester valid
    #1;
    chk("rst ready",     64'(req_ready), 64'd0);
    chk("rst mem_en",    64'(mem_en),    64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge clk); @(negedge clk);
    ram_load = 1'b0;
    rst_n = 1'b1;

    // 1. Reset while a read response is in flight
    req_valid = 4'b0001; v_addr[0] = 13'h10;
    tick("t1 rd");
    rst_n = 1'b0;
    #1;
    chk("t1 rsp dropped", 64'(rsp_valid), 64'd0);
    chk("t1 ready in rst", 64'(req_ready), 64'd0);
    m_reset();
    @(posedge clk); @(negedge clk);
    chk("t1 rsp still 0", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;

    // 2. All four read 0x10..0x13: strict rotation from ptr=0
    req_valid = '1;
    for (int i = 0; i < N; i++) v_addr[i] = AW'(16 + i);
    for (int k = 0; k < 9; k++) begin
      if (k == 8) req_valid = '0;
      tick("t2");
      if (k < 8) chk_i("t2 grant", obs_g, k % N);
      if (k >= 1) begin
        chk("t2 rsp id",   64'(obs_rsp_vld), 64'(1 << ((k - 1) % N)));
        chk("t2 rsp data", 64'(obs_rsp),     64'(seed_word(AW'(16 + (k - 1) % N))));
      end
    end

    // 3. Write then read-after-write on the same address
    old5 = seed_word(13'h5);
    req_valid = 4'b0100; req_we = 4'b0100; v_addr[2] = 13'h5; v_wdata[2] = 32'hDEADBEEF;
    tick("t3 wr");
    chk_i("t3 wr grant", obs_g, 2);
    req_valid = 4'b0001; req_we = '0; v_addr[0] = 13'h5;
    tick("t3 rd");
    chk_i("t3 rd grant", obs_g, 0);
    chk("t3 wr rsp id",  64'(obs_rsp_vld), 64'b0100);
    chk("t3 wr old data", 64'(obs_rsp),    64'(old5));
    req_valid = '0;
    tick("t3 drain");
    chk("t3 rd rsp id",  64'(obs_rsp_vld), 64'b0001);
    chk("t3 rd data",    64'(obs_rsp),     64'hDEADBEEF);

    // 4. Req 1 holds lock: LOCK_MAX+1 grants, then req 2
    req_valid = '1; req_lock = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick("t4");
      chk_i("t4 grant", obs_g, (k < LM + 1) ? 1 : 2);
    end
    req_valid = '0; req_lock = '0;
    tick("t4 drain");

    // 5. Locked owner drops valid: one empty cycle, then req 0 (ptr wrapped to 0)
    req_valid = 4'b1001; req_lock = 4'b1000;
    tick("t5 lock");
    chk_i("t5 lock grant", obs_g, 3);
    req_valid = 4'b0001; req_lock = '0;
    tick("t5 drop");
    chk_i("t5 empty", obs_g, -1);
    tick("t5 next");
    chk_i("t5 req0", obs_g, 0);
    req_valid = '0;
    tick("t5 drain");

    // 6. Idle
    for (int k = 0; k < 3; k++) begin
      tick("t6");
      chk("t6 ready",  64'(req_ready), 64'd0);
      chk("t6 mem_en", 64'(mem_en),    64'd0);
      chk("t6 rsp",    64'(obs_rsp_vld), 64'd0);
    end

    // Randomized traffic on a small address window so reads meet earlier writes
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      req_lock  = N'($urandom & $urandom);
      req_we    = N'($urandom);
      for (int i = 0; i < N; i++) begin
        v_addr[i]  = AW'($urandom_range(0, 15));
        v_wdata[i] = $urandom;
      end
      tick("rnd");
    end
    req_valid = '0; req_lock = '0;
    tick("rnd drain");
    tick("rnd idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
